// File: rtl/uv_border_cache_if.sv
// ============================================================================
//  Module      : uv_border_cache_if
//  Description : Bundle between the macroblock sequencer / chroma DC
//                predictor (master) and the U/V border cache (slave).
//                Request:    req, req_x, req_y, ready
//                Issue:      pred_start, x, y, top_u/v, left_u/v, pred_done
//                Write-back: wb_valid, wb_bottom_u/v, wb_right_u/v, wb_ready
//                Status:     err
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uv_border_cache_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int BLOCK_NUM  = 10
);
    localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;

    logic                 req;
    logic [BLOCK_NUM-1:0] req_x;
    logic [BLOCK_NUM-1:0] req_y;
    logic                 ready;
    logic                 pred_start;
    logic [BLOCK_NUM-1:0] x;
    logic [BLOCK_NUM-1:0] y;
    logic [ROW_W-1:0]     top_u;
    logic [ROW_W-1:0]     top_v;
    logic [ROW_W-1:0]     left_u;
    logic [ROW_W-1:0]     left_v;
    logic                 pred_done;
    logic                 wb_valid;
    logic [ROW_W-1:0]     wb_bottom_u;
    logic [ROW_W-1:0]     wb_bottom_v;
    logic [ROW_W-1:0]     wb_right_u;
    logic [ROW_W-1:0]     wb_right_v;
    logic                 wb_ready;
    logic                 err;

    modport slave (
        input  req, req_x, req_y, pred_done,
        input  wb_valid, wb_bottom_u, wb_bottom_v, wb_right_u, wb_right_v,
        output ready, pred_start, x, y, top_u, top_v, left_u, left_v,
        output wb_ready, err
    );

    modport master (
        output req, req_x, req_y, pred_done,
        output wb_valid, wb_bottom_u, wb_bottom_v, wb_right_u, wb_right_v,
        input  ready, pred_start, x, y, top_u, top_v, left_u, left_v,
        input  wb_ready, err
    );
endinterface

`default_nettype wire

// File: rtl/uv_border_cache.sv
// ============================================================================
//  Module      : uv_border_cache
//  Description : Neighbour-sample cache for the chroma DC predictor.
//                Holds a line buffer of bottom U/V rows per macroblock column
//                and the right U/V column of the previous macroblock. On a
//                request it presents x/y/top/left, pulses pred_start, holds
//                until pred_done, then accepts the reconstructed borders.
//  Ports       : clk, rst_n (async, active low)
//                bus - uv_border_cache_if.slave (request, issue, write-back,
//                      sticky err)
//  Options     : PRED_TIMEOUT_EN - bounds WAIT to 255 cycles; on expiry err
//                is set and the block returns to IDLE without write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uv_border_cache #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int BLOCK_NUM  = 10,
    parameter int LB_AW      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uv_border_cache_if.slave   bus
);
    localparam int ROW_W    = BIT_WIDTH * BLOCK_SIZE;
    localparam int LB_DEPTH = 1 << LB_AW;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_FETCH = 5'b00010,
        ST_ISSUE = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_WB    = 5'b10000
    } state_t;

    state_t               r_state;
    logic                 r_ready;
    logic                 r_pred_start;
    logic                 r_wb_ready;
    logic                 r_err;
    logic [BLOCK_NUM-1:0] r_x;
    logic [BLOCK_NUM-1:0] r_y;
    logic [ROW_W-1:0]     r_top_u;
    logic [ROW_W-1:0]     r_top_v;
    logic [ROW_W-1:0]     r_left_u;
    logic [ROW_W-1:0]     r_left_v;
    logic [ROW_W-1:0]     r_left_reg_u;
    logic [ROW_W-1:0]     r_left_reg_v;
`ifdef PRED_TIMEOUT_EN
    logic [7:0]           r_to_cnt;
`endif

    // Line buffer: {bottom_v, bottom_u} per macroblock column, no reset.
    logic [2*ROW_W-1:0]   r_line [0:LB_DEPTH-1];

    logic [LB_AW-1:0]     w_addr;
    logic [2*ROW_W-1:0]   w_rd_data;
    logic                 w_wr_en;
    logic                 w_x_oob;

    assign w_addr    = r_x[LB_AW-1:0];
    assign w_rd_data = r_line[w_addr];
    // rst_n term keeps the buffer untouched while reset is asserted.
    assign w_wr_en   = (r_state == ST_WB) && bus.wb_valid && rst_n;
    assign w_x_oob   = 32'(bus.req_x) >= (32'd1 << LB_AW);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_line[w_addr] <= {bus.wb_bottom_v, bus.wb_bottom_u};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_pred_start <= 1'b0;
            r_wb_ready   <= 1'b0;
            r_err        <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_top_u      <= '0;
            r_top_v      <= '0;
            r_left_u     <= '0;
            r_left_v     <= '0;
            r_left_reg_u <= '0;
            r_left_reg_v <= '0;
`ifdef PRED_TIMEOUT_EN
            r_to_cnt     <= 8'd0;
`endif
        end else begin
            r_pred_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        if (w_x_oob) begin
                            r_err <= 1'b1;
                        end else begin
                            r_x     <= bus.req_x;
                            r_y     <= bus.req_y;
                            r_ready <= 1'b0;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    // Synchronous read of line[x]; the neighbour registers and
                    // pred_start are loaded together so they are valid for
                    // the whole ISSUE cycle.
                    r_top_u      <= (r_y == '0) ? '0 : w_rd_data[ROW_W-1:0];
                    r_top_v      <= (r_y == '0) ? '0 : w_rd_data[2*ROW_W-1:ROW_W];
                    r_left_u     <= (r_x == '0) ? '0 : r_left_reg_u;
                    r_left_v     <= (r_x == '0) ? '0 : r_left_reg_v;
                    r_pred_start <= 1'b1;
                    r_state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
`ifdef PRED_TIMEOUT_EN
                    r_to_cnt <= 8'd0;
`endif
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.pred_done) begin
                        r_wb_ready <= 1'b1;
                        r_state    <= ST_WB;
`ifdef PRED_TIMEOUT_EN
                    end else if (r_to_cnt == 8'd254) begin
                        // 255th WAIT cycle without pred_done: abandon.
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
`endif
                    end
                end
                ST_WB: begin
                    if (bus.wb_valid) begin
                        r_left_reg_u <= bus.wb_right_u;
                        r_left_reg_v <= bus.wb_right_v;
                        r_wb_ready   <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_wb_ready <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = r_ready;
    assign bus.pred_start = r_pred_start;
    assign bus.wb_ready   = r_wb_ready;
    assign bus.err        = r_err;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.top_u      = r_top_u;
    assign bus.top_v      = r_top_v;
    assign bus.left_u     = r_left_u;
    assign bus.left_v     = r_left_v;

endmodule

`default_nettype wire

// File: tb/tb_uv_border_cache.sv
// ============================================================================
//  Module      : tb_uv_border_cache
//  Description : Self-checking bench for uv_border_cache. Expected issue
//                values come from a small line-buffer/left-column model and
//                are queued at request time, then compared on pred_start.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uv_border_cache;
    localparam int BW    = 8;
    localparam int BS    = 8;
    localparam int BN    = 10;
    localparam int AW    = 8;
    localparam int ROW_W = BW * BS;

    typedef struct {
        logic [BN-1:0]    x;
        logic [BN-1:0]    y;
        logic [ROW_W-1:0] tu;
        logic [ROW_W-1:0] tv;
        logic [ROW_W-1:0] lu;
        logic [ROW_W-1:0] lv;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    uv_border_cache_if #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .BLOCK_NUM(BN)) bus ();

    uv_border_cache #(
        .BIT_WIDTH (BW),
        .BLOCK_SIZE(BS),
        .BLOCK_NUM (BN),
        .LB_AW     (AW)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   ps_count = 0;
    exp_t sb[$];
    exp_t cur_exp;

    logic [2*ROW_W-1:0] m_line [int];
    logic [ROW_W-1:0]   m_left_u;
    logic [ROW_W-1:0]   m_left_v;

    task automatic check_value(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every pred_start must match a queued request.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (rst_n === 1'b1 && bus.pred_start === 1'b1) begin
            ps_count++;
            if (sb.size() == 0) begin
                check_value("spurious_pred_start", 1, 0);
            end else begin
                e = sb.pop_front();
                check_value("issue_x",       bus.x,      e.x);
                check_value("issue_y",       bus.y,      e.y);
                check_value("issue_top_u",   bus.top_u,  e.tu);
                check_value("issue_top_v",   bus.top_v,  e.tv);
                check_value("issue_left_u",  bus.left_u, e.lu);
                check_value("issue_left_v",  bus.left_v, e.lv);
                check_value("issue_latency", cyc,        e.cyc);
            end
        end
    end

    task automatic issue_req(input int x, input int y);
        exp_t e;
        int   k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) break;
        end
        if (k == 50) check_value("ready_timeout", 0, 1);
        e.x   = BN'(x);
        e.y   = BN'(y);
        if (y == 0 || !m_line.exists(x)) begin
            e.tu = '0;
            e.tv = '0;
        end else begin
            e.tu = m_line[x][ROW_W-1:0];
            e.tv = m_line[x][2*ROW_W-1:ROW_W];
        end
        e.lu  = (x == 0) ? '0 : m_left_u;
        e.lv  = (x == 0) ? '0 : m_left_v;
        e.cyc = cyc + 2;
        sb.push_back(e);
        cur_exp   = e;
        bus.req   = 1'b1;
        bus.req_x = BN'(x);
        bus.req_y = BN'(y);
        @(negedge clk);
        bus.req   = 1'b0;
    endtask

    task automatic wait_pred_start(input int prev);
        int k;
        for (k = 0; k < 10; k++) begin
            if (ps_count > prev) break;
            @(negedge clk);
        end
        if (ps_count <= prev) check_value("pred_start_timeout", 0, 1);
    endtask

    task automatic do_mb(input int x, input int y, input int done_dly, input bit req_in_wait,
                         input logic [ROW_W-1:0] bu, input logic [ROW_W-1:0] bv,
                         input logic [ROW_W-1:0] ru, input logic [ROW_W-1:0] rv);
        int prev;
        prev = ps_count;
        issue_req(x, y);
        wait_pred_start(prev);
        for (int i = 0; i < done_dly; i++) begin
            @(negedge clk);
            if (req_in_wait) begin
                bus.req   = (i == 3);
                bus.req_x = BN'(5);
                bus.req_y = BN'(0);
            end
            if (i == done_dly - 1) begin
                check_value("wait_wb_ready", bus.wb_ready, 0);
                check_value("wait_x",        bus.x,        cur_exp.x);
                check_value("wait_y",        bus.y,        cur_exp.y);
                check_value("wait_top_u",    bus.top_u,    cur_exp.tu);
                check_value("wait_left_u",   bus.left_u,   cur_exp.lu);
            end
        end
        bus.req = 1'b0;
        if (req_in_wait) check_value("no_second_ps", ps_count, prev + 1);
        @(negedge clk);
        bus.pred_done = 1'b1;
        @(negedge clk);
        bus.pred_done   = 1'b0;
        check_value("wb_ready", bus.wb_ready, 1);
        bus.wb_valid    = 1'b1;
        bus.wb_bottom_u = bu;
        bus.wb_bottom_v = bv;
        bus.wb_right_u  = ru;
        bus.wb_right_v  = rv;
        @(negedge clk);
        bus.wb_valid = 1'b0;
        check_value("ready_after_wb", bus.ready, 1);
        m_line[x] = {bv, bu};
        m_left_u  = ru;
        m_left_v  = rv;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        rst_n           = 1'b0;
        bus.req         = 1'b0;
        bus.req_x       = '0;
        bus.req_y       = '0;
        bus.pred_done   = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_bottom_u = '0;
        bus.wb_bottom_v = '0;
        bus.wb_right_u  = '0;
        bus.wb_right_v  = '0;
        m_left_u        = '0;
        m_left_v        = '0;
        repeat (3) @(negedge clk);
        check_value("rst_ready",      bus.ready,      1);
        check_value("rst_pred_start", bus.pred_start, 0);
        check_value("rst_wb_ready",   bus.wb_ready,   0);
        check_value("rst_err",        bus.err,        0);
        check_value("rst_x",          bus.x,          0);
        check_value("rst_top_u",      bus.top_u,      0);
        check_value("rst_left_v",     bus.left_v,     0);
        rst_n = 1'b1;
        @(negedge clk);

        // Raster: (0,0), (1,0) with slow predictor and stray req, then (0,1).
        do_mb(0, 0, 0,  1'b0, {8{8'h10}}, {8{8'h20}}, {8{8'h30}}, {8{8'h40}});
        do_mb(1, 0, 20, 1'b1, {8{8'h11}}, {8{8'h21}}, {8{8'h31}}, {8{8'h41}});
        do_mb(0, 1, 2,  1'b0, {8{8'h12}}, {8{8'h22}}, {8{8'h32}}, {8{8'h42}});
        do_mb(1, 1, 1,  1'b0, 64'h0102030405060708, 64'h1112131415161718,
              64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8);

        // Predictor never finishes.
        prev = ps_count;
        issue_req(2, 0);
        wait_pred_start(prev);
        repeat (300) @(negedge clk);
`ifdef PRED_TIMEOUT_EN
        check_value("to_err",      bus.err,      1);
        check_value("to_ready",    bus.ready,    1);
        check_value("to_wb_ready", bus.wb_ready, 0);
`else
        check_value("stall_err",      bus.err,      0);
        check_value("stall_ready",    bus.ready,    0);
        check_value("stall_wb_ready", bus.wb_ready, 0);
`endif

        // Asynchronous reset in the middle of an operation.
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_ready",    bus.ready,    1);
        check_value("mid_rst_wb_ready", bus.wb_ready, 0);
        check_value("mid_rst_err",      bus.err,      0);
        check_value("mid_rst_top_u",    bus.top_u,    0);
        m_left_u = '0;
        m_left_v = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_mb(3, 0, 0, 1'b0, {8{8'h55}}, {8{8'h66}}, {8{8'h77}}, {8{8'h88}});

        // Out-of-range column.
        prev = ps_count;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.req_x = BN'(256);
        bus.req_y = BN'(0);
        @(negedge clk);
        bus.req = 1'b0;
        check_value("oob_err",   bus.err,   1);
        check_value("oob_ready", bus.ready, 1);
        repeat (5) @(negedge clk);
        check_value("oob_no_ps", ps_count, prev);
        check_value("oob_err_sticky", bus.err, 1);

        check_value("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
